// File: rtl/image_fetch_ctrl_if.sv
// Handshake bundle between the image fetch controller, the image memory and the pixel datapath.
// The master modport is the controller's view of this bundle.
interface image_fetch_ctrl_if #(
   parameter int CW = 8
);
   logic          Start;
   logic          Ready;
   logic [7:0]    dina;
   logic          Lock;
   logic [7:0]    pix_out;
   logic          pix_valid;
   logic [CW-1:0] row;
   logic [CW-1:0] col;
   logic          Busy;
   logic          Done;

   modport master (
      input  Start, Ready, dina,
      output Lock, pix_out, pix_valid, row, col, Busy, Done
   );

   modport slave (
      output Start, Ready, dina,
      input  Lock, pix_out, pix_valid, row, col, Busy, Done
   );
endinterface

// File: rtl/image_fetch_ctrl.sv
// Sequences the registered-output image memory: drops the priming reads after reset, then
// streams one frame as valid pixels with row/col coordinates, honouring downstream Ready.
module image_fetch_ctrl #(
   parameter int IMG_W        = 256,
   parameter int IMG_H        = 256,
   parameter int PRIME_CYCLES = 2,
   parameter int CW           = 8
) (
   input logic                CLK,
   input logic                RST_N,
   image_fetch_ctrl_if.master fetch
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int IW   = $clog2(NPIX) + 1;
   localparam int PW   = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;

   localparam logic [IW-1:0] LAST_ISSUE = IW'(NPIX - 1);
   localparam logic [IW-1:0] NPIX_C     = IW'(NPIX);
   localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_CYCLES - 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
   localparam logic [CW-1:0] ROW_LAST   = CW'(IMG_H - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PRIME  = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [PW-1:0] prime_cnt_q, prime_cnt_d;
   logic [IW-1:0] issued_q, issued_d;
   logic          primed_q, primed_d;
   logic          pix_valid_q, pix_valid_d;
   logic [CW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          lock;

   // Ready is an advance acceptance, so the memory only steps when the next pixel is already wanted.
   always_comb begin
      lock = (state_q == S_PRIME) ||
             ((state_q == S_STREAM) && fetch.Ready && (issued_q < NPIX_C));
   end

   assign fetch.Lock      = lock;
   assign fetch.pix_out   = fetch.dina;
   assign fetch.pix_valid = pix_valid_q;
   assign fetch.row       = row_q;
   assign fetch.col       = col_q;
   assign fetch.Busy      = (state_q != S_IDLE);
   assign fetch.Done      = (state_q == S_DONE);

   always_comb begin
      state_d     = state_q;
      prime_cnt_d = prime_cnt_q;
      issued_d    = issued_q;
      primed_d    = primed_q;
      case (state_q)
         S_IDLE: begin
            if (fetch.Start) begin
               issued_d = '0;
               if (primed_q) begin
                  state_d = S_STREAM;
               end else begin
                  state_d     = S_PRIME;
                  prime_cnt_d = '0;
               end
            end
         end
         S_PRIME: begin
            prime_cnt_d = prime_cnt_q + 1'b1;
            if (prime_cnt_q == PRIME_LAST) begin
               state_d  = S_STREAM;
               primed_d = 1'b1;
            end
         end
         S_STREAM: begin
            if (lock) begin
               issued_d = issued_q + 1'b1;
               if (issued_q == LAST_ISSUE) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Coordinates advance after each emitted pixel and wrap back to (0,0) after the last one.
   always_comb begin
      pix_valid_d = (state_q == S_STREAM) && lock;
      row_d       = row_q;
      col_d       = col_q;
      if (pix_valid_q) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         prime_cnt_q <= '0;
         issued_q    <= '0;
         primed_q    <= 1'b0;
         pix_valid_q <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
      end else begin
         state_q     <= state_d;
         prime_cnt_q <= prime_cnt_d;
         issued_q    <= issued_d;
         primed_q    <= primed_d;
         pix_valid_q <= pix_valid_d;
         row_q       <= row_d;
         col_q       <= col_d;
      end
   end

endmodule

// File: tb/tb_image_fetch_ctrl.sv
// Directed bench for image_fetch_ctrl on a 4x2 frame with a registered-output memory model
// whose first two reads after reset return junk.
module tb_image_fetch_ctrl;

   localparam int W = 4;
   localparam int H = 2;
   localparam int P = 2;

   localparam int PH_IDLE   = 0;
   localparam int PH_PRIME  = 1;
   localparam int PH_STREAM = 2;
   localparam int PH_DRAIN  = 3;
   localparam int PH_DONE   = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   image_fetch_ctrl_if #(.CW(8)) fif ();

   image_fetch_ctrl #(
      .IMG_W(W), .IMG_H(H), .PRIME_CYCLES(P), .CW(8)
   ) dut (
      .CLK  (clk),
      .RST_N(rst_n),
      .fetch(fif)
   );

   int checks = 0;
   int errors = 0;

   // Memory model: reset alongside the controller; priming reads do not consume addresses.
   int         junk_cnt;
   logic [7:0] mem_addr;
   always @(posedge clk) begin
      if (!rst_n) begin
         junk_cnt <= 0;
         mem_addr <= 8'd0;
      end else if (fif.Lock) begin
         if (junk_cnt < P) begin
            fif.dina <= 8'hxx;
            junk_cnt <= junk_cnt + 1;
         end else begin
            fif.dina <= mem_addr;
            mem_addr <= mem_addr + 8'd1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"},      32'(fif.Busy),      32'd0);
      chk({tag, "_done"},      32'(fif.Done),      32'd0);
      chk({tag, "_lock"},      32'(fif.Lock),      32'd0);
      chk({tag, "_pix_valid"}, 32'(fif.pix_valid), 32'd0);
      chk({tag, "_row"},       32'(fif.row),       32'd0);
      chk({tag, "_col"},       32'(fif.col),       32'd0);
   endtask

   // mode 0: Ready=1; mode 1: Ready 1,0,0,1 repeating; mode 2: Ready=0 in PRIME, then mode 1.
   task automatic run_frame(input int base, input bit expect_prime, input int mode,
                            input bit hold_start, input int abort_after);
      int         phase;
      int         pcnt;
      int         issued;
      int         n;
      int         k;
      bit         exp_valid;
      bit         exp_lock;
      bit         rdy;
      bit         prev_rdy;
      logic [3:0] pat;
      pat        = 4'b1001;
      fif.Start  = 1'b1;
      fif.Ready  = 1'b1;
      tick();
      if (!hold_start) fif.Start = 1'b0;
      phase     = expect_prime ? PH_PRIME : PH_STREAM;
      pcnt      = 0;
      issued    = 0;
      n         = 0;
      exp_valid = 1'b0;
      prev_rdy  = 1'b1;
      for (k = 0; k < 200; k++) begin
         chk("busy",      32'(fif.Busy),      32'(phase != PH_IDLE));
         chk("done",      32'(fif.Done),      32'(phase == PH_DONE));
         chk("pix_valid", 32'(fif.pix_valid), 32'(exp_valid));
         if (!prev_rdy && phase != PH_PRIME)
            chk("valid_after_not_ready", 32'(fif.pix_valid), 32'd0);
         if (exp_valid) begin
            chk("pix_out", 32'(fif.pix_out), 32'((base + n) & 8'hff));
            chk("row",     32'(fif.row),     32'(n / W));
            chk("col",     32'(fif.col),     32'(n % W));
            n++;
         end
         if (phase == PH_IDLE) break;
         if (abort_after > 0 && n == abort_after) begin
            rst_n     = 1'b0;
            fif.Start = 1'b0;
            fif.Ready = 1'b1;
            tick();
            chk_quiet("abort");
            rst_n = 1'b1;
            tick();
            chk_quiet("abort_after");
            return;
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = pat[k % 4];
            default: rdy = (phase == PH_PRIME) ? 1'b0 : pat[k % 4];
         endcase
         fif.Ready = rdy;
         #1;
         exp_lock = (phase == PH_PRIME) || (phase == PH_STREAM && rdy && issued < W * H);
         chk("lock", 32'(fif.Lock), 32'(exp_lock));
         exp_valid = (phase == PH_STREAM) && exp_lock;
         prev_rdy  = rdy;
         case (phase)
            PH_PRIME: begin
               pcnt++;
               if (pcnt == P) phase = PH_STREAM;
            end
            PH_STREAM: begin
               if (exp_lock) begin
                  issued++;
                  if (issued == W * H) phase = PH_DRAIN;
               end
            end
            PH_DRAIN: phase = PH_DONE;
            PH_DONE:  phase = PH_IDLE;
            default:  phase = PH_IDLE;
         endcase
         @(posedge clk);
         #1;
      end
      chk("pix_count", 32'(n), 32'(W * H));
      chk("end_row",   32'(fif.row), 32'd0);
      chk("end_col",   32'(fif.col), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      fif.Start = 1'b0;
      fif.Ready = 1'b1;
      tick();
      tick();
      #1;
      chk_quiet("reset");
      rst_n = 1'b1;
      tick();
      chk_quiet("post_reset_idle");

      // First frame with priming, Ready always high.
      run_frame(0, 1'b1, 0, 1'b0, 0);
      repeat (2) begin
         tick();
         chk_quiet("idle_a");
      end

      // Already primed: no PRIME, Ready toggling.
      run_frame(8, 1'b0, 1, 1'b0, 0);

      // Start held through the whole frame yields exactly one frame.
      run_frame(16, 1'b0, 0, 1'b1, 0);
      fif.Start = 1'b0;
      repeat (3) begin
         tick();
         chk_quiet("idle_hold");
      end

      // Reset after the third pixel aborts without Done.
      run_frame(24, 1'b0, 0, 1'b0, 3);

      // After the abort, priming is redone; Ready low during PRIME.
      run_frame(0, 1'b1, 2, 1'b0, 0);
      tick();
      chk_quiet("final_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/image_fetch_ctrl.md
Name: image_fetch_ctrl

Overview:
- Sequencing controller for the external image memory (8-bit read port, registered output, advances one address per clock while Lock=1).
- Drives Lock and discards the memory's priming reads after reset.
- Converts the raw byte stream into a framed pixel stream with valid, row/column coordinates, downstream backpressure and a completion pulse.
- Sits between the image memory and the pixel-processing datapath.

Parameters:
- IMG_W, 256, pixels per row.
- IMG_H, 256, rows per frame.
- PRIME_CYCLES, 2, Lock-high cycles after reset whose returned data is junk and must be discarded.
- CW, 8, width of row/col outputs; must satisfy 2^CW >= max(IMG_W, IMG_H).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- Start  in  1  request one frame; sampled only in IDLE.
- Ready  in  1  downstream will accept a pixel in the next cycle.
- dina  in  8  byte from image memory; valid the cycle after a Lock-high edge.
- Lock  out  1  memory advance enable.
- pix_out  out  8  pixel data.
- pix_valid  out  1  pix_out/row/col valid this cycle.
- row  out  CW  row index of pix_out.
- col  out  CW  column index of pix_out.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse at frame end.

Behaviour:
- Interface: one clock, CLK; reset RST_N is synchronous and active-low.
- Reset (RST_N=0 at an edge):
  - state=IDLE, primed=0, all counters 0.
  - pix_valid=0, Done=0, row=0, col=0, Busy=0, Lock=0.
  - pix_out is don't-care.
- Reset mid-frame aborts immediately with no Done pulse. The memory address is not reset by this block; the integrator resets the memory alongside.
- States: IDLE, PRIME, STREAM, DRAIN, DONE.
- Lock is combinational: Lock = (state==PRIME) | (state==STREAM & Ready & issued < IMG_W*IMG_H).
- IDLE:
  - Start=1 and primed=0 -> PRIME, prime_cnt=0.
  - Start=1 and primed=1 -> STREAM, skipping priming.
  - Start ignored in every other state.
- PRIME:
  - Lock=1 every cycle; Ready is ignored.
  - prime_cnt increments each cycle.
  - When prime_cnt reaches PRIME_CYCLES-1 -> STREAM and set primed=1.
  - Data returned for these cycles never raises pix_valid.
- STREAM:
  - issued counter (width >= log2(IMG_W*IMG_H)+1) increments on each Lock-high cycle.
  - When issued reaches IMG_W*IMG_H after an increment -> DRAIN.
- DRAIN: single cycle, lets the last pixel emerge, then -> DONE.
- DONE: Done=1 for exactly one cycle, then -> IDLE. Busy falls in IDLE.
- Pixel valid:
  - pix_valid register <= (state==STREAM & Lock).
  - pix_out = dina, combinational pass-through (memory output is already registered).
  - Latency: Lock edge -> pix_valid/pix_out one cycle later.
- Backpressure protocol: Ready is an advance acceptance. Downstream must take every pixel where pix_valid=1 whenever Ready was high the prior cycle. If Ready=0, Lock=0 and the memory holds; no pixel is lost or duplicated.
- Coordinates:
  - row/col give the position of the pixel currently valid; first pixel is (0,0).
  - After each pix_valid: col+1; at col==IMG_W-1, col wraps to 0 and row+1.
  - At frame end row and col return to 0.
- Pixel count: exactly IMG_W*IMG_H pix_valid pulses per frame, regardless of Ready pattern.
- Simultaneous events: Start during DONE is ignored; it must be reasserted in IDLE.

Test Plan:
- Bench params IMG_W=4, IMG_H=2, PRIME_CYCLES=2. Memory model: byte k at address k; first 2 reads after reset return 0xXX.
- Reset, Start pulse, Ready=1 -> Lock high 2+8 cycles. Eight pix_valid carry 0x00..0x07 with (row,col) (0,0)..(1,3). Done pulses 1 cycle after DRAIN. Busy low afterwards.
- Same, Ready toggling 1,0,0,1,... -> still 8 pixels 0x00..0x07 in order. pix_valid never asserted in the cycle after Ready=0. Lock low whenever Ready low in STREAM.
- Second Start after Done (primed=1) -> no PRIME. Pixels 0x08..0x0F, coordinates restart at (0,0).
- Start held high throughout the frame -> exactly one frame. Start seen again only in IDLE begins the next frame.
- RST_N=0 after the 3rd pixel -> next cycle Lock=0, pix_valid=0, Busy=0, no Done. New Start re-enters PRIME.
- Ready=0 during PRIME -> Lock still high for both prime cycles; no pix_valid during PRIME.
